// File: rtl/xor_resp_checker.sv
// Response checker for a registered XOR datapath: predicts in1 ^ in2, aligns it to the DUT latency,
// counts checks and mismatches, and reports pass/fail. Define XOR_CHK_FIRST_FAIL_EN for first-mismatch capture ports.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting vectors until NUM_VEC have been taken
// DRAIN | all vectors accepted, waiting for outstanding compares
// DONE  | result reported, held until start or reset
module xor_resp_checker #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] stim_a,
  input  logic [WIDTH-1:0] stim_b,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
`ifdef XOR_CHK_FIRST_FAIL_EN
  ,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH-1:0] fail_exp,
  output logic [WIDTH-1:0] fail_got
`endif
);

  localparam int              AW        = (NUM_VEC < 2) ? 1 : $clog2(NUM_VEC + 1);
  localparam logic [AW-1:0]   ACC_LOAD  = AW'(NUM_VEC);
  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]    acc_left;
  logic [LATENCY-1:0] dl_vld;
  logic [WIDTH-1:0] dl_exp [LATENCY];

  logic clear;
  logic accept;
  logic compare;
  logic mismatch;
  logic [WIDTH-1:0] head_exp;

  assign clear    = start && ((state == IDLE) || (state == DONE));
  assign accept   = (state == RUN) && stim_valid && (acc_left != '0);
  assign head_exp = dl_exp[LATENCY-1];
  assign compare  = dl_vld[LATENCY-1] && ((state == RUN) || (state == DRAIN));
  assign mismatch = compare && (dut_out != head_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (acc_left == '0) state_nxt = DRAIN;
      DRAIN:   if (chk_cnt == NUM_VEC_C) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Down-counter of vectors still to accept; reaching zero ends RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_left <= '0;
    end else if (clear) begin
      acc_left <= ACC_LOAD;
    end else if (accept) begin
      acc_left <= acc_left - 1'b1;
    end
  end

  // Every slot advances each clock; idle cycles push a bubble so gapped stimulus stays aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_exp[i] <= '0;
      end
    end else if (clear) begin
      dl_vld <= '0;
    end else begin
      dl_vld[0] <= accept;
      dl_exp[0] <= stim_a ^ stim_b;
      for (int i = 1; i < LATENCY; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_exp[i] <= dl_exp[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt <= '0;
      err_cnt <= '0;
    end else if (clear) begin
      chk_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (compare && (chk_cnt != CNT_MAX)) begin
        chk_cnt <= chk_cnt + 1'b1;
      end
      if (mismatch && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

`ifdef XOR_CHK_FIRST_FAIL_EN
  logic fail_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (clear) begin
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (mismatch && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_idx  <= chk_cnt;
      fail_exp  <= head_exp;
      fail_got  <= dut_out;
    end
  end
`endif

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_xor_resp_checker.sv
// Bench for xor_resp_checker: a 1-bit/latency-1 instance driven from a scenario table and hand sequences,
// and an 8-bit/latency-3/5-vector instance driven with random runs checked against a list-based model.
module tb_xor_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   edge_cnt = 0;
  int   passed = 0;
  int   total = 0;

  // instance 0: WIDTH 1, LATENCY 1, NUM_VEC 4
  logic       start0, sv0, a0, b0, dut0;
  logic       busy0, done0, pass0;
  logic [7:0] err0, chk0;
  int         fm0;
  // instance 1: WIDTH 8, LATENCY 3, NUM_VEC 5
  logic       start1, sv1;
  logic [7:0] a1, b1, m1, dut1;
  logic       busy1, done1, pass1;
  logic [7:0] err1, chk1;
  logic [7:0] p1 [3];
`ifdef XOR_CHK_FIRST_FAIL_EN
  logic [7:0] fidx0, fidx1, fexp1, fgot1;
  logic       fexp0, fgot0;
`endif

  xor_resp_checker #(.WIDTH(1), .LATENCY(1), .NUM_VEC(4), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim_valid(sv0),
    .stim_a(a0), .stim_b(b0), .dut_out(dut0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .chk_cnt(chk0)
`ifdef XOR_CHK_FIRST_FAIL_EN
    , .fail_idx(fidx0), .fail_exp(fexp0), .fail_got(fgot0)
`endif
  );

  xor_resp_checker #(.WIDTH(8), .LATENCY(3), .NUM_VEC(5), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stim_valid(sv1),
    .stim_a(a1), .stim_b(b1), .dut_out(dut1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .chk_cnt(chk1)
`ifdef XOR_CHK_FIRST_FAIL_EN
    , .fail_idx(fidx1), .fail_exp(fexp1), .fail_got(fgot1)
`endif
  );

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // DUT models: fm0 0=correct 1=stuck0 2=stuck1 3=inverted; m1 is a per-vector corruption mask.
  always @(posedge clk) begin
    case (fm0)
      1:       dut0 <= 1'b0;
      2:       dut0 <= 1'b1;
      3:       dut0 <= ~(a0 ^ b0);
      default: dut0 <= a0 ^ b0;
    endcase
    p1[0] <= a1 ^ b1 ^ m1;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign dut1 = p1[2];

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    else passed++;
  endtask

  typedef struct {
    logic [7:0] vecs;   // vector i = {a,b} in bits [2i+1:2i]
    int         fm;
    int         gap;
    bit         sv;     // stim_valid asserted together with start
    int         e_err;
    int         e_pass;
    int         e_fidx;
    int         e_fexp;
    int         e_fgot;
  } vec0_t;

  vec0_t tv0 [6];

  task automatic wait_done0(output int de);
    int n = 0;
    while (done0 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done0_seen", int'(done0), 1);
    de = edge_cnt;
  endtask

  task automatic run0(input int idx);
    vec0_t t;
    logic [7:0] vv;
    int last, de;
    t  = tv0[idx];
    vv = t.vecs;
    last = 0;
    @(negedge clk);
    fm0 = t.fm; start0 = 1'b1; sv0 = t.sv; a0 = 1'b1; b0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0; sv0 = 1'b0;
    check("run0_busy", int'(busy0), 1);
    for (int i = 0; i < 4; i++) begin
      {a0, b0} = vv[2*i +: 2];
      sv0 = 1'b1;
      @(negedge clk);
      sv0 = 1'b0;
      last = edge_cnt;
      if (i < 3) repeat (t.gap) @(negedge clk);
    end
    wait_done0(de);
    check("run0_done_edge", de, last + 2);
    check("run0_chk", int'(chk0), 4);
    check("run0_err", int'(err0), t.e_err);
    check("run0_pass", int'(pass0), t.e_pass);
    check("run0_busy_off", int'(busy0), 0);
`ifdef XOR_CHK_FIRST_FAIL_EN
    check("run0_fidx", int'(fidx0), t.e_fidx);
    check("run0_fexp", int'(fexp0), t.e_fexp);
    check("run0_fgot", int'(fgot0), t.e_fgot);
`endif
  endtask

  logic [7:0] va [5];
  logic [7:0] vb [5];
  logic [7:0] vm [5];
  int         vg [5];

  task automatic run1();
    int e_err, e_fidx, last, de, n;
    logic [7:0] e_fexp, e_fgot;
    e_err = 0; e_fidx = -1; e_fexp = 8'h00; e_fgot = 8'h00; last = 0;
    for (int i = 0; i < 5; i++) begin
      if (vm[i] != 8'h00) begin
        e_err++;
        if (e_fidx < 0) begin
          e_fidx = i;
          e_fexp = va[i] ^ vb[i];
          e_fgot = va[i] ^ vb[i] ^ vm[i];
        end
      end
    end
    @(negedge clk);
    start1 = 1'b1; sv1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    check("run1_busy", int'(busy1), 1);
    for (int i = 0; i < 5; i++) begin
      a1 = va[i]; b1 = vb[i]; m1 = vm[i]; sv1 = 1'b1;
      @(negedge clk);
      sv1 = 1'b0;
      last = edge_cnt;
      a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255)); m1 = 8'($urandom_range(0, 255));
      if (i < 4) repeat (vg[i]) @(negedge clk);
    end
    n = 0;
    while (done1 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done1_seen", int'(done1), 1);
    de = edge_cnt;
    check("run1_done_edge", de, last + 4);
    check("run1_chk", int'(chk1), 5);
    check("run1_err", int'(err1), e_err);
    check("run1_pass", int'(pass1), (e_err == 0) ? 1 : 0);
`ifdef XOR_CHK_FIRST_FAIL_EN
    check("run1_fidx", int'(fidx1), (e_fidx < 0) ? 0 : e_fidx);
    check("run1_fexp", int'(fexp1), int'(e_fexp));
    check("run1_fgot", int'(fgot1), int'(e_fgot));
`endif
  endtask

  initial begin
    tv0[0] = '{8'hB4, 0, 0, 1'b0, 0, 1, 0, 0, 0};
    tv0[1] = '{8'hB4, 1, 0, 1'b0, 2, 0, 1, 1, 0};
    tv0[2] = '{8'hB4, 0, 2, 1'b0, 0, 1, 0, 0, 0};
    tv0[3] = '{8'h5F, 2, 1, 1'b1, 2, 0, 0, 0, 1};
    tv0[4] = '{8'h5F, 3, 0, 1'b0, 4, 0, 0, 0, 1};
    tv0[5] = '{8'hB4, 1, 1, 1'b1, 2, 0, 1, 1, 0};

    rst_n = 1'b0; fm0 = 0;
    start0 = 1'b0; sv0 = 1'b0; a0 = 1'b0; b0 = 1'b0;
    start1 = 1'b0; sv1 = 1'b0; a1 = 8'h00; b1 = 8'h00; m1 = 8'h00;
    #12;
    check("rst_busy0", int'(busy0), 0);
    check("rst_done0", int'(done0), 0);
    check("rst_pass0", int'(pass0), 0);
    check("rst_err0", int'(err0), 0);
    check("rst_chk0", int'(chk0), 0);
    check("rst_busy1", int'(busy1), 0);
    check("rst_chk1", int'(chk1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_done0", int'(done0), 0);

    for (int k = 0; k < 6; k++) run0(k);

    // Overrun vector after the fourth accept, then start + stim_valid while draining.
    fm0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a0 = 1'b1; b0 = 1'(i); sv0 = 1'b1;
      @(negedge clk);
    end
    a0 = 1'b1; b0 = 1'b0; sv0 = 1'b1;
    @(negedge clk);
    check("ovr_drain_busy", int'(busy0), 1);
    start0 = 1'b1; sv0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; sv0 = 1'b0;
    check("ovr_done", int'(done0), 1);
    check("ovr_chk", int'(chk0), 4);
    check("ovr_busy", int'(busy0), 0);
    @(negedge clk);
    check("ovr_chk_hold", int'(chk0), 4);
    check("ovr_done_hold", int'(done0), 1);
    check("ovr_pass", int'(pass0), 1);

    // Reset mid-run after two vectors (both mismatching under stuck-at-0).
    fm0 = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a0 = 1'b0; b0 = 1'b1; sv0 = 1'b1;
      @(negedge clk);
    end
    sv0 = 1'b0;
    check("mid_chk", int'(chk0), 1);
    check("mid_err", int'(err0), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy0), 0);
    check("arst_done", int'(done0), 0);
    check("arst_chk", int'(chk0), 0);
    check("arst_err", int'(err0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run0(0);

    // Wide instance: bit 7 corrupted on the third vector, back-to-back vectors.
    va = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    vb = '{8'hFF, 8'h0F, 8'hF0, 8'h33, 8'hC3};
    vm = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
    vg = '{0, 0, 0, 0, 0};
    run1();

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 5; i++) begin
        va[i] = 8'($urandom_range(0, 255));
        vb[i] = 8'($urandom_range(0, 255));
        vm[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        vg[i] = int'($urandom_range(0, 3));
      end
      run1();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
